// File: rtl/id_issue_ctrl_if.sv
// IF -> decode -> EX handshake bundle for id_issue_ctrl.
// The slave modport is the controller's view; the master modport is the driver of IF and the EX sink.
interface id_issue_ctrl_if #(
   parameter int XLEN       = 32,
   parameter int IMM_TYPE_W = 3
);
   logic                  if_valid;
   logic                  if_ready;
   logic [XLEN-1:0]       if_instr;
   logic [XLEN-1:0]       if_pc;
   logic                  ex_valid;
   logic                  ex_ready;
   logic [XLEN-1:0]       ex_instr;
   logic [XLEN-1:0]       ex_pc;
   logic [IMM_TYPE_W-1:0] ex_imm_type;
   logic                  ex_uses_imm;
   logic                  ex_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, ex_ready,
      output if_ready, ex_valid, ex_instr, ex_pc, ex_imm_type, ex_uses_imm, ex_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, ex_ready,
      input  if_ready, ex_valid, ex_instr, ex_pc, ex_imm_type, ex_uses_imm, ex_illegal
   );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode-stage sequencer: 2-entry skid buffer (OUT + SKID), immediate-type decode, load-use bubble, flush.
// Optional macro ID_ILLEGAL_CHK_EN enables unknown-opcode detection on ex_illegal.
module id_issue_ctrl #(
   parameter int XLEN       = 32,
   parameter int IMM_TYPE_W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   id_issue_ctrl_if.slave bus
);
   localparam logic [IMM_TYPE_W-1:0] IMM_I   = IMM_TYPE_W'(0);
   localparam logic [IMM_TYPE_W-1:0] IMM_S   = IMM_TYPE_W'(1);
   localparam logic [IMM_TYPE_W-1:0] IMM_B   = IMM_TYPE_W'(2);
   localparam logic [IMM_TYPE_W-1:0] IMM_U   = IMM_TYPE_W'(3);
   localparam logic [IMM_TYPE_W-1:0] IMM_J   = IMM_TYPE_W'(4);
   localparam logic [IMM_TYPE_W-1:0] IMM_CSR = IMM_TYPE_W'(5);

   typedef struct packed {
      logic [XLEN-1:0]       instr;
      logic [XLEN-1:0]       pc;
      logic [IMM_TYPE_W-1:0] imm_type;
      logic                  uses_imm;
      logic                  is_load;
      logic                  rd_rs1;
      logic                  rd_rs2;
`ifdef ID_ILLEGAL_CHK_EN
      logic                  illegal;
`endif
   } entry_t;

   typedef enum logic {RUN, BUBBLE} state_t;

   function automatic entry_t decode(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
      entry_t e;
      e          = '0;
      e.instr    = instr;
      e.pc       = pc;
      e.imm_type = IMM_I;
      e.rd_rs1   = 1'b1;
      case (instr[6:0])
         7'b0000011: begin e.uses_imm = 1'b1; e.is_load = 1'b1; end
         7'b0010011,
         7'b1100111: e.uses_imm = 1'b1;
         7'b0100011: begin e.imm_type = IMM_S; e.uses_imm = 1'b1; e.rd_rs2 = 1'b1; end
         7'b1100011: begin e.imm_type = IMM_B; e.uses_imm = 1'b1; e.rd_rs2 = 1'b1; end
         7'b0110111,
         7'b0010111: begin e.imm_type = IMM_U; e.uses_imm = 1'b1; e.rd_rs1 = 1'b0; end
         7'b1101111: begin e.imm_type = IMM_J; e.uses_imm = 1'b1; e.rd_rs1 = 1'b0; end
         7'b1110011: begin e.imm_type = IMM_CSR; e.uses_imm = 1'b1; end
         7'b0110011: begin
            e.rd_rs2 = 1'b1;
`ifdef ID_ILLEGAL_CHK_EN
            e.illegal = !(instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000);
`endif
         end
         default: begin
`ifdef ID_ILLEGAL_CHK_EN
            e.illegal = 1'b1;
`endif
         end
      endcase
`ifdef ID_ILLEGAL_CHK_EN
      // Illegal instructions never stall and never arm the load tracker.
      if (e.illegal) begin
         e.rd_rs1  = 1'b0;
         e.rd_rs2  = 1'b0;
         e.is_load = 1'b0;
      end
`endif
      return e;
   endfunction

   entry_t     out_q, out_d, skid_q, skid_d, in_e;
   logic       out_vld, out_vld_d, skid_vld, skid_vld_d, rdy_q;
   logic       ld_pend, ld_pend_d;
   logic [4:0] ld_rd, ld_rd_d;
   state_t     state_q, state_d;
   logic       accept, hazard, ex_vld_c, issue;

   always_comb begin
      accept   = bus.if_valid & rdy_q;
      hazard   = (state_q == RUN) & ld_pend & out_vld &
                 ((out_q.rd_rs1 & (out_q.instr[19:15] == ld_rd)) |
                  (out_q.rd_rs2 & (out_q.instr[24:20] == ld_rd)));
      // The hazard cycle itself is the single bubble; BUBBLE is the recovery cycle with ld_pend clear.
      ex_vld_c = out_vld & ~hazard;
      issue    = ex_vld_c & bus.ex_ready;
      in_e     = decode(bus.if_instr, bus.if_pc);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (hazard) state_d = BUBBLE;
         BUBBLE:  state_d = RUN;
         default: state_d = RUN;
      endcase
      if (flush) state_d = RUN;
   end

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld;
      skid_d     = skid_q;
      skid_vld_d = skid_vld;
      if (!out_vld || issue) begin
         if (skid_vld) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            out_d     = in_e;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_e;
         skid_vld_d = 1'b1;
      end
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end
   end

   always_comb begin
      ld_pend_d = ld_pend;
      ld_rd_d   = ld_rd;
      if (issue) begin
         ld_pend_d = out_q.is_load & (out_q.instr[11:7] != 5'd0);
         ld_rd_d   = out_q.instr[11:7];
      end else if (!out_vld || hazard || state_q == BUBBLE) begin
         ld_pend_d = 1'b0;
      end
      if (flush) ld_pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b1;
         ld_pend  <= 1'b0;
         ld_rd    <= 5'd0;
         state_q  <= RUN;
      end else begin
         out_q    <= out_d;
         skid_q   <= skid_d;
         out_vld  <= out_vld_d;
         skid_vld <= skid_vld_d;
         rdy_q    <= ~skid_vld_d;
         ld_pend  <= ld_pend_d;
         ld_rd    <= ld_rd_d;
         state_q  <= state_d;
      end
   end

   assign bus.if_ready    = rdy_q;
   assign bus.ex_valid    = ex_vld_c;
   assign bus.ex_instr    = out_q.instr;
   assign bus.ex_pc       = out_q.pc;
   assign bus.ex_imm_type = out_q.imm_type;
   assign bus.ex_uses_imm = out_q.uses_imm;
`ifdef ID_ILLEGAL_CHK_EN
   assign bus.ex_illegal  = out_q.illegal;
`else
   assign bus.ex_illegal  = 1'b0;
`endif
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: decode table stream plus backpressure, load-use, flush and reset sequences.
module tb_id_issue_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   n_cmp = 0;
   int   n_err = 0;

   id_issue_ctrl_if #(.XLEN(32), .IMM_TYPE_W(3)) bus ();

   id_issue_ctrl #(.XLEN(32), .IMM_TYPE_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef ID_ILLEGAL_CHK_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  typ;
      logic        imm;
      logic        ill;
   } vec_t;

   vec_t tv [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.if_valid = v;
      bus.if_instr = instr;
      bus.if_pc    = pc;
   endtask

   initial begin
      tv[0] = '{32'h00500093, 3'd0, 1'b1, 1'b0};  // addi x1,x0,5
      tv[1] = '{32'h00112023, 3'd1, 1'b1, 1'b0};  // sw
      tv[2] = '{32'hFE000EE3, 3'd2, 1'b1, 1'b0};  // beq
      tv[3] = '{32'h123452B7, 3'd3, 1'b1, 1'b0};  // lui x5,0x12345
      tv[4] = '{32'h008000EF, 3'd4, 1'b1, 1'b0};  // jal x1,8
      tv[5] = '{32'h305110F3, 3'd5, 1'b1, 1'b0};  // csrrw x1,0x305,x2
      tv[6] = '{32'h00238333, 3'd0, 1'b0, 1'b0};  // add x6,x7,x2
      tv[7] = '{32'h0000A283, 3'd0, 1'b1, 1'b0};  // lw x5,0(x1)
      tv[8] = '{32'h00000017, 3'd3, 1'b1, 1'b0};  // auipc x0,0
      tv[9] = '{32'h0000007F, 3'd0, 1'b0, ILL};   // unknown opcode

      rst_n = 1'b0;
      flush = 1'b0;
      bus.ex_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      step();
      step();
      chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst if_ready", 32'(bus.if_ready), 32'd1);
      chk("rst ex_instr", bus.ex_instr, 32'd0);
      chk("rst ex_pc", bus.ex_pc, 32'd0);
      chk("rst imm_type", 32'(bus.ex_imm_type), 32'd0);
      chk("rst uses_imm", 32'(bus.ex_uses_imm), 32'd0);
      chk("rst illegal", 32'(bus.ex_illegal), 32'd0);
      rst_n = 1'b1;
      step();

      // Stream: each instruction appears one cycle after its accept, back to back.
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tv%0d if_ready", i), 32'(bus.if_ready), 32'd1);
         drive(1'b1, tv[i].instr, 32'h1000 + 32'(4 * i));
         step();
         chk($sformatf("tv%0d ex_valid", i), 32'(bus.ex_valid), 32'd1);
         chk($sformatf("tv%0d ex_instr", i), bus.ex_instr, tv[i].instr);
         chk($sformatf("tv%0d ex_pc", i), bus.ex_pc, 32'h1000 + 32'(4 * i));
         chk($sformatf("tv%0d imm_type", i), 32'(bus.ex_imm_type), 32'(tv[i].typ));
         chk($sformatf("tv%0d uses_imm", i), 32'(bus.ex_uses_imm), 32'(tv[i].imm));
         chk($sformatf("tv%0d illegal", i), 32'(bus.ex_illegal), 32'(tv[i].ill));
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("drain ex_valid", 32'(bus.ex_valid), 32'd0);

      // Backpressure: OUT + SKID fill, third is refused, FIFO order on release.
      bus.ex_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h2000);
      step();
      chk("bp A valid", 32'(bus.ex_valid), 32'd1);
      chk("bp B if_ready", 32'(bus.if_ready), 32'd1);
      drive(1'b1, 32'h00200113, 32'h2004);
      step();
      chk("bp full if_ready", 32'(bus.if_ready), 32'd0);
      drive(1'b1, 32'h00300193, 32'h2008);
      step();
      chk("bp hold if_ready", 32'(bus.if_ready), 32'd0);
      chk("bp hold instr", bus.ex_instr, 32'h00100093);
      chk("bp hold pc", bus.ex_pc, 32'h2000);
      bus.ex_ready = 1'b1;
      step();
      chk("bp B instr", bus.ex_instr, 32'h00200113);
      chk("bp B valid", 32'(bus.ex_valid), 32'd1);
      chk("bp C if_ready", 32'(bus.if_ready), 32'd1);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("bp C instr", bus.ex_instr, 32'h00300193);
      chk("bp C pc", bus.ex_pc, 32'h2008);
      step();
      chk("bp no dup", 32'(bus.ex_valid), 32'd0);

      // Load-use: lw x5 then add x6,x5,x2 -> exactly one bubble.
      drive(1'b1, 32'h0000A283, 32'h3000);
      step();
      chk("lu lw valid", 32'(bus.ex_valid), 32'd1);
      drive(1'b1, 32'h00228333, 32'h3004);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("lu bubble", 32'(bus.ex_valid), 32'd0);
      step();
      chk("lu add valid", 32'(bus.ex_valid), 32'd1);
      chk("lu add instr", bus.ex_instr, 32'h00228333);
      step();
      chk("lu add once", 32'(bus.ex_valid), 32'd0);

      // lw x5 then add x6,x7,x2 -> no bubble.
      drive(1'b1, 32'h0000A283, 32'h3100);
      step();
      drive(1'b1, 32'h00238333, 32'h3104);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("nh valid", 32'(bus.ex_valid), 32'd1);
      chk("nh instr", bus.ex_instr, 32'h00238333);
      step();

      // lw x0 then add x6,x0,x2 -> no bubble.
      drive(1'b1, 32'h0000A003, 32'h3200);
      step();
      drive(1'b1, 32'h00200333, 32'h3204);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("x0 valid", 32'(bus.ex_valid), 32'd1);
      chk("x0 instr", bus.ex_instr, 32'h00200333);
      step();

      // Flush with OUT + SKID full and if_valid high.
      bus.ex_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h4000);
      step();
      drive(1'b1, 32'h00200113, 32'h4004);
      step();
      drive(1'b1, 32'h00300193, 32'h4008);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      bus.ex_ready = 1'b1;
      chk("fl ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("fl if_ready", 32'(bus.if_ready), 32'd1);
      step();
      chk("fl gone", 32'(bus.ex_valid), 32'd0);
      drive(1'b1, 32'h00400213, 32'h400C);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("fl next instr", bus.ex_instr, 32'h00400213);
      chk("fl next valid", 32'(bus.ex_valid), 32'd1);

      // Reset mid-stream.
      drive(1'b1, 32'h123452B7, 32'h5000);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      chk("mrst ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("mrst ex_instr", bus.ex_instr, 32'd0);
      chk("mrst ex_pc", bus.ex_pc, 32'd0);
      chk("mrst imm_type", 32'(bus.ex_imm_type), 32'd0);
      chk("mrst uses_imm", 32'(bus.ex_uses_imm), 32'd0);
      chk("mrst if_ready", 32'(bus.if_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
